// File: rtl/snake_dir_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : snake_dir_arbiter
// Description : Converts debounced direction-button activity into turn
//               events, arbitrates simultaneous presses round-robin, rejects
//               180-degree reversals, queues turns in a small FIFO and applies
//               one turn per game tick.
//               Optional feature macro: TICK_BYPASS_EN (an empty FIFO lets a
//               qualifying turn that coincides with a tick go straight to dir).
// Revision    : 1.0 - initial release
// ============================================================================
module snake_dir_arbiter #(
    parameter int         QDEPTH   = 2,
    parameter int         PTR_W    = 1,
    parameter logic [1:0] INIT_DIR = 2'd3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       btn_act,
    input  logic             tick,
    output logic [1:0]       dir,
    output logic             dir_upd,
    output logic             drop,
    output logic [PTR_W:0]   q_count
);

    localparam logic [PTR_W:0]   c_full    = (PTR_W+1)'(QDEPTH);
    localparam logic [PTR_W-1:0] c_ptr_one = PTR_W'(1);

    logic [3:0]       r_btn_prev;
    logic [1:0]       r_rr;
    logic [1:0]       r_fifo [QDEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic [1:0]       r_dir;
    logic             r_dir_upd;
    logic             r_drop;

    logic [3:0]       w_ev;
    logic [1:0]       w_grant;
    logic             w_any;
    logic             w_multi;
    logic [PTR_W-1:0] w_tail_idx;
    logic [1:0]       w_ref;
    logic             w_same;
    logic             w_opp;
    logic             w_full;
    logic             w_empty;
    logic             w_qual;
    logic             w_push;
    logic             w_pop;
    logic             w_bypass;
    logic             w_drop;

    // Rising edges of the debounced buttons; more than one set bit means
    // all but the granted one are discarded.
    assign w_ev    = btn_act & ~r_btn_prev;
    assign w_multi = |(w_ev & (w_ev - 4'd1));

    // Round-robin scan starting at r_rr: first set event bit wins.
    always_comb begin
        logic [1:0] idx;
        w_grant = 2'd0;
        w_any   = 1'b0;
        idx     = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx = r_rr + k[1:0];
            if (!w_any && w_ev[idx]) begin
                w_any   = 1'b1;
                w_grant = idx;
            end
        end
    end

    // Reference direction is the last queued turn, or the live direction
    // when nothing is queued; sampled before any pop this cycle.
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == c_full);
    assign w_tail_idx = r_wr_ptr - c_ptr_one;
    assign w_ref      = w_empty ? r_dir : r_fifo[w_tail_idx];
    assign w_same     = (w_grant == w_ref);
    assign w_opp      = (w_grant[1] == w_ref[1]) && (w_grant[0] != w_ref[0]);
    assign w_qual     = w_any & ~w_same & ~w_opp & ~w_full;
    assign w_pop      = tick & ~w_empty;

`ifdef TICK_BYPASS_EN
    assign w_bypass = w_qual & tick & w_empty;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_push = w_qual & ~w_bypass;
    assign w_drop = w_multi | (w_any & ~w_same & (w_opp | w_full));

    // Turn storage; contents are only meaningful where r_count says so.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= w_grant;
        end
    end

    // Control state: edge detect, arbitration pointer, FIFO pointers,
    // direction register and the two status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_btn_prev <= 4'b1111;
            r_rr       <= 2'd0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_dir      <= INIT_DIR;
            r_dir_upd  <= 1'b0;
            r_drop     <= 1'b0;
        end else begin
            r_btn_prev <= btn_act;
            if (w_any) begin
                r_rr <= w_grant + 2'd1;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_dir    <= r_fifo[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end else if (w_bypass) begin
                r_dir <= w_grant;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            r_dir_upd <= w_pop | w_bypass;
            r_drop    <= w_drop;
        end
    end

    assign dir     = r_dir;
    assign dir_upd = r_dir_upd;
    assign drop    = r_drop;
    assign q_count = r_count;

endmodule
`default_nettype wire
